// File: rtl/axi2mem_pkg.sv
// Shared constants and types for the axi2mem synch/response path.
package axi2mem_pkg;

  localparam int unsigned DEFAULT_ID_WIDTH = 6;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    RESP  = 2'd2
  } synch_state_e;

endpackage

// File: rtl/axi2mem_buffer.sv
// Small FIFO with registered empty/full flags; a same-cycle pop never frees a slot for push.
module axi2mem_buffer #(
  parameter int unsigned DATA_WIDTH   = 6,
  parameter int unsigned BUFFER_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int unsigned PtrWidth = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int unsigned CntWidth = $clog2(BUFFER_DEPTH + 1);
  localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(BUFFER_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
  logic [PtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  empty_q, full_q;
  logic                  push_en, pop_en;

  assign push_en = push_i && !full_q;
  assign pop_en  = pop_i && !empty_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = empty_q;
  assign full_o  = full_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push_en && !pop_en) begin
      cnt_d = cnt_q + CntWidth'(1);
    end else if (pop_en && !push_en) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (push_en) begin
        wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrWidth'(1);
      end
      if (pop_en) begin
        rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrWidth'(1);
      end
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == CntWidth'(BUFFER_DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/axi2mem_synch_rsp.sv
// Turns joined synch tokens into AXI B responses once all outstanding TCDM traffic has drained.
// Define AXI2MEM_SYNCH_ERR_EN to add tcdm_err_i and a sticky SLVERR response flag.
module axi2mem_synch_rsp
  import axi2mem_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = DEFAULT_ID_WIDTH,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                synch_req_i,
  input  logic [ID_WIDTH-1:0] synch_id_i,
  output logic                synch_gnt_o,
  input  logic                tcdm_issue_i,
  input  logic                tcdm_done_i,
`ifdef AXI2MEM_SYNCH_ERR_EN
  input  logic                tcdm_err_i,
`endif
  output logic                b_valid_o,
  output logic [ID_WIDTH-1:0] b_id_o,
  output logic [1:0]          b_resp_o,
  input  logic                b_ready_i,
  output logic                busy_o
);

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  synch_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  fifo_empty, fifo_full;
  logic                  push, pop;
  logic [ID_WIDTH-1:0]   head_id;

  assign synch_gnt_o = !fifo_full;
  assign push        = synch_req_i && !fifo_full;
  assign pop         = (state_q == RESP) && b_ready_i;

  axi2mem_buffer #(
    .DATA_WIDTH   (ID_WIDTH),
    .BUFFER_DEPTH (FIFO_DEPTH)
  ) u_token_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (synch_id_i),
    .pop_i   (pop),
    .data_o  (head_id),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Saturate at both ends; hitting either bound is a protocol violation upstream.
  always_comb begin
    cnt_d = cnt_q;
    if (tcdm_issue_i && !tcdm_done_i && cnt_q != CntMax) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else if (tcdm_done_i && !tcdm_issue_i && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty) state_d = DRAIN;
      DRAIN:   if (cnt_q == '0 && !tcdm_issue_i) state_d = RESP;
      RESP:    if (b_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign b_valid_o = (state_q == RESP);
  assign b_id_o    = b_valid_o ? head_id : '0;
  assign busy_o    = !fifo_empty || (cnt_q != '0) || (state_q != IDLE);

`ifdef AXI2MEM_SYNCH_ERR_EN
  logic err_q, err_d;

  // An error landing in the handshake cycle belongs to the next response.
  assign err_d = (err_q && !pop) || (tcdm_done_i && tcdm_err_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign b_resp_o = (b_valid_o && err_q) ? RESP_SLVERR : RESP_OKAY;
`else
  assign b_resp_o = RESP_OKAY;
`endif

  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(tcdm_issue_i && !tcdm_done_i && cnt_q == CntMax))
        else $error("axi2mem_synch_rsp: TCDM issue with outstanding counter at maximum");
      assert (!(tcdm_done_i && !tcdm_issue_i && cnt_q == '0))
        else $error("axi2mem_synch_rsp: TCDM done with no outstanding request");
    end
  end

endmodule
